// File: rtl/encrypt_pkg.sv
// encrypt_pkg: shared parameters, FSM state encoding and ciphertext vector type for the LWE encrypt engine.
package encrypt_pkg;
    localparam int PLAINTEXT_MODULUS  = 64;
    localparam int PLAINTEXT_WIDTH    = 6;
    localparam int DIMENSION          = 1;
    localparam int CIPHERTEXT_MODULUS = 1024;
    localparam int CIPHERTEXT_WIDTH   = 10;
    localparam int BIG_N              = 30;
    localparam int DELTA_SHIFT        = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;
    localparam int ADDR_WIDTH         = $clog2(BIG_N);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    typedef logic [DIMENSION:0][CIPHERTEXT_WIDTH-1:0] ct_vec_t;

    // (m*DELTA mod q, 0, ..., 0); DELTA = q/t is a power of two, so scaling is a shift
    function automatic ct_vec_t scale_msg(input logic [PLAINTEXT_WIDTH-1:0] m);
        scale_msg    = '0;
        scale_msg[0] = CIPHERTEXT_WIDTH'(m) << DELTA_SHIFT;
    endfunction
endpackage

// File: rtl/encrypt_accum.sv
// encrypt_accum: DIMENSION+1 lane accumulator mod 2**CIPHERTEXT_WIDTH with clear, load and add-enable.
module encrypt_accum
    import encrypt_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clear,
    input  logic    load,
    input  ct_vec_t init,
    input  logic    add_en,
    input  ct_vec_t addend,
    output ct_vec_t acc
);
    // lanes wrap naturally because q is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (load)
            acc <= init;
        else if (add_en)
            for (int j = 0; j <= DIMENSION; j++)
                acc[j] <= acc[j] + addend[j];
    end
endmodule

// File: rtl/encrypt.sv
// encrypt: LWE (Regev) public-key encryption; sums mask-selected key rows and adds the scaled message.
module encrypt
    import encrypt_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PLAINTEXT_WIDTH-1:0] plaintext,
    input  logic [BIG_N-1:0]           rand_bits,
    output logic                       pk_rd_en,
    output logic [ADDR_WIDTH-1:0]      pk_addr,
    input  ct_vec_t                    pk_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output ct_vec_t                    cipher_text
);
    if (CIPHERTEXT_MODULUS != 2**CIPHERTEXT_WIDTH || PLAINTEXT_MODULUS != 2**PLAINTEXT_WIDTH) begin : g_param_check
        $error("encrypt: moduli must be powers of two matching their widths");
    end

    state_t            state;
    logic [BIG_N-1:0]  mask;
    logic              rd_d;
    logic              sel_d;
    logic              accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign pk_rd_en  = (state == FETCH);
    assign accept    = in_valid && in_ready;

    // mask shifts right each fetch so bit 0 always belongs to the row being read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pk_addr <= '0;
            mask    <= '0;
            rd_d    <= 1'b0;
            sel_d   <= 1'b0;
        end else begin
            rd_d  <= pk_rd_en;
            sel_d <= mask[0];
            case (state)
                IDLE: if (accept) begin
                    state   <= FETCH;
                    pk_addr <= '0;
                    mask    <= rand_bits;
                end
                FETCH: begin
                    mask <= mask >> 1;
                    if (pk_addr == ADDR_WIDTH'(BIG_N - 1))
                        state <= DRAIN;
                    else
                        pk_addr <= pk_addr + ADDR_WIDTH'(1);
                end
                DRAIN: state <= DONE;
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // the accumulator register doubles as the ciphertext output register
    encrypt_accum u_accum (
        .clk    (clk),
        .rst    (rst),
        .clear  (1'b0),
        .load   (accept),
        .init   (scale_msg(plaintext)),
        .add_en (rd_d && sel_d),
        .addend (pk_row),
        .acc    (cipher_text)
    );
endmodule

// File: tb/tb_encrypt.sv
// tb_encrypt: scoreboard bench for encrypt with a registered key-RAM model.
module tb_encrypt;
    import encrypt_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       in_valid = 1'b0;
    logic                       out_ready = 1'b0;
    logic [PLAINTEXT_WIDTH-1:0] plaintext = '0;
    logic [BIG_N-1:0]           rand_bits = '0;
    logic                       in_ready, pk_rd_en, out_valid;
    logic [ADDR_WIDTH-1:0]      pk_addr;
    ct_vec_t                    pk_row = '0;
    ct_vec_t                    cipher_text;

    ct_vec_t key [BIG_N];
    ct_vec_t exp_q [$];
    int pass_cnt = 0, total = 0, rd_cnt = 0, addr_bad = 0;

    encrypt dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .rand_bits(rand_bits), .pk_rd_en(pk_rd_en),
        .pk_addr(pk_addr), .pk_row(pk_row), .out_valid(out_valid),
        .out_ready(out_ready), .cipher_text(cipher_text)
    );

    always #5 clk = ~clk;

    // key RAM: one-cycle read latency; also logs read count and address order
    always @(posedge clk) begin
        if (pk_rd_en) begin
            pk_row <= key[pk_addr];
            if (pk_addr !== ADDR_WIDTH'(rd_cnt)) addr_bad++;
            rd_cnt++;
        end
    end

    function automatic ct_vec_t model(input logic [PLAINTEXT_WIDTH-1:0] pt, input logic [BIG_N-1:0] rb);
        int s [DIMENSION+1];
        ct_vec_t r;
        for (int j = 0; j <= DIMENSION; j++) s[j] = 0;
        s[0] = int'(pt) * (CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS);
        for (int i = 0; i < BIG_N; i++)
            if (rb[i])
                for (int j = 0; j <= DIMENSION; j++) s[j] += int'(key[i][j]);
        for (int j = 0; j <= DIMENSION; j++) r[j] = CIPHERTEXT_WIDTH'(s[j] % CIPHERTEXT_MODULUS);
        return r;
    endfunction

    task automatic rand_key();
        for (int i = 0; i < BIG_N; i++)
            for (int j = 0; j <= DIMENSION; j++) key[i][j] = CIPHERTEXT_WIDTH'($urandom);
    endtask

    task automatic go(input logic [PLAINTEXT_WIDTH-1:0] pt, input logic [BIG_N-1:0] rb);
        plaintext = pt;
        rand_bits = rb;
        in_valid  = 1'b1;
        exp_q.push_back(model(pt, rb));
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    // latency in cycles from the accept cycle to the first cycle with out_valid
    task automatic wait_out(output int lat);
        int n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({pk_rd_en, out_valid} !== 2'b00) $display("FAIL reset_strobes: got %b, expected 00", {pk_rd_en, out_valid}); else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, expected 1", in_ready); else pass_cnt++;
        total++; if (pk_addr !== '0) $display("FAIL reset_addr: got %0d, expected 0", pk_addr); else pass_cnt++;
        total++; if (cipher_text !== '0) $display("FAIL reset_ct: got %h, expected 0", cipher_text); else pass_cnt++;
    endtask

    task automatic test_zero_mask();
        int lat;
        ct_vec_t e;
        ct_vec_t c = {10'd0, 10'd80};
        rand_key();
        rd_cnt = 0; addr_bad = 0;
        go(6'd5, '0);
        wait_out(lat);
        e = exp_q.pop_front();
        total++; if (lat !== BIG_N + 2) $display("FAIL zero_latency: got %0d, expected %0d", lat, BIG_N + 2); else pass_cnt++;
        total++; if (cipher_text !== e) $display("FAIL zero_ct_model: got %h, expected %h", cipher_text, e); else pass_cnt++;
        total++; if (cipher_text !== c) $display("FAIL zero_ct_const: got %h, expected %h", cipher_text, c); else pass_cnt++;
        total++; if (rd_cnt !== BIG_N) $display("FAIL zero_read_count: got %0d, expected %0d", rd_cnt, BIG_N); else pass_cnt++;
        total++; if (addr_bad !== 0) $display("FAIL zero_addr_order: got %0d bad, expected 0", addr_bad); else pass_cnt++;
        ack();
        total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL zero_handshake: got %b, expected 01", {out_valid, in_ready}); else pass_cnt++;
    endtask

    task automatic test_all_rows();
        int lat;
        ct_vec_t e;
        for (int i = 0; i < BIG_N; i++) begin
            key[i][0] = CIPHERTEXT_WIDTH'(i);
            key[i][1] = CIPHERTEXT_WIDTH'(2 * i);
        end
        go(6'd5, '1);
        wait_out(lat);
        e = exp_q.pop_front();
        total++; if (cipher_text !== e) $display("FAIL all_rows_model: got %h, expected %h", cipher_text, e); else pass_cnt++;
        total++; if (cipher_text[0] !== 10'd515) $display("FAIL all_rows_ct0: got %0d, expected 515", cipher_text[0]); else pass_cnt++;
        total++; if (cipher_text[1] !== 10'd870) $display("FAIL all_rows_ct1: got %0d, expected 870", cipher_text[1]); else pass_cnt++;
        ack();
    endtask

    task automatic test_wrap();
        int lat;
        ct_vec_t e;
        ct_vec_t c = {10'd1021, 10'd1021};
        for (int i = 0; i < BIG_N; i++) key[i] = {10'd1023, 10'd1023};
        go(6'd0, BIG_N'(3'b111));
        wait_out(lat);
        e = exp_q.pop_front();
        total++; if (cipher_text !== e) $display("FAIL wrap_model: got %h, expected %h", cipher_text, e); else pass_cnt++;
        total++; if (cipher_text !== c) $display("FAIL wrap_const: got %h, expected %h", cipher_text, c); else pass_cnt++;
        ack();
    endtask

    task automatic test_backpressure();
        int lat;
        ct_vec_t e;
        rand_key();
        go(PLAINTEXT_WIDTH'($urandom), BIG_N'($urandom));
        wait_out(lat);
        e = exp_q.pop_front();
        total++; if (cipher_text !== e) $display("FAIL bp_ct: got %h, expected %h", cipher_text, e); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, cipher_text} !== {1'b1, 1'b0, e})
                $display("FAIL bp_hold%0d: got v=%b r=%b ct=%h, expected v=1 r=0 ct=%h", k, out_valid, in_ready, cipher_text, e);
            else pass_cnt++;
        end
        ack();
        total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release: got %b, expected 01", {out_valid, in_ready}); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        ct_vec_t e;
        ct_vec_t c = {10'd0, 10'd16};
        rand_key();
        go(PLAINTEXT_WIDTH'($urandom), '1);
        repeat (9) begin @(posedge clk); #1; end
        total++; if (pk_rd_en !== 1'b1) $display("FAIL mid_fetching: got %b, expected 1", pk_rd_en); else pass_cnt++;
        rst = 1'b1;
        #1;
        total++; if ({pk_rd_en, out_valid} !== 2'b00) $display("FAIL mid_strobes: got %b, expected 00", {pk_rd_en, out_valid}); else pass_cnt++;
        total++; if (cipher_text !== '0) $display("FAIL mid_ct: got %h, expected 0", cipher_text); else pass_cnt++;
        exp_q.delete();
        rd_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (rd_cnt !== 0) $display("FAIL mid_no_reads: got %0d, expected 0", rd_cnt); else pass_cnt++;
        go(6'd1, '0);
        wait_out(lat);
        e = exp_q.pop_front();
        total++; if (lat !== BIG_N + 2) $display("FAIL mid_latency: got %0d, expected %0d", lat, BIG_N + 2); else pass_cnt++;
        total++; if (cipher_text !== e) $display("FAIL mid_model: got %h, expected %h", cipher_text, e); else pass_cnt++;
        total++; if (cipher_text !== c) $display("FAIL mid_const: got %h, expected %h", cipher_text, c); else pass_cnt++;
        ack();
    endtask

    task automatic test_hold_input();
        int n = 1, busy_bad = 0, lat;
        ct_vec_t e;
        logic [PLAINTEXT_WIDTH-1:0] p1 = PLAINTEXT_WIDTH'($urandom);
        logic [BIG_N-1:0] r1 = BIG_N'($urandom);
        rand_key();
        plaintext = PLAINTEXT_WIDTH'($urandom);
        rand_bits = BIG_N'($urandom);
        in_valid  = 1'b1;
        exp_q.push_back(model(plaintext, rand_bits));
        @(posedge clk); #1;
        while (!out_valid && n < 200) begin
            plaintext = PLAINTEXT_WIDTH'($urandom);
            rand_bits = BIG_N'($urandom);
            if (in_ready) busy_bad++;
            @(posedge clk); #1;
            n++;
        end
        e = exp_q.pop_front();
        total++; if (busy_bad !== 0) $display("FAIL hold_busy: got %0d ready cycles, expected 0", busy_bad); else pass_cnt++;
        total++; if (n !== BIG_N + 2) $display("FAIL hold_latency: got %0d, expected %0d", n, BIG_N + 2); else pass_cnt++;
        total++; if (cipher_text !== e) $display("FAIL hold_ct: got %h, expected %h", cipher_text, e); else pass_cnt++;
        plaintext = p1;
        rand_bits = r1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL hold_reopen: got %b, expected 01", {out_valid, in_ready}); else pass_cnt++;
        exp_q.push_back(model(p1, r1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) $display("FAIL hold_reaccept: got %b, expected 0", in_ready); else pass_cnt++;
        wait_out(lat);
        e = exp_q.pop_front();
        total++; if (lat !== BIG_N + 2) $display("FAIL hold2_latency: got %0d, expected %0d", lat, BIG_N + 2); else pass_cnt++;
        total++; if (cipher_text !== e) $display("FAIL hold2_ct: got %h, expected %h", cipher_text, e); else pass_cnt++;
        ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        ct_vec_t e;
        rand_key();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            go(PLAINTEXT_WIDTH'($urandom), BIG_N'($urandom));
            wait_out(lat);
            e = exp_q.pop_front();
            total++; if (lat !== BIG_N + 2) $display("FAIL b2b_latency%0d: got %0d, expected %0d", k, lat, BIG_N + 2); else pass_cnt++;
            total++; if (cipher_text !== e) $display("FAIL b2b_ct%0d: got %h, expected %h", k, cipher_text, e); else pass_cnt++;
            @(posedge clk); #1;
            total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL b2b_done_one_cycle%0d: got %b, expected 01", k, {out_valid, in_ready}); else pass_cnt++;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_mask();
        test_all_rows();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_hold_input();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/encrypt.md
Name: encrypt

Overview:
- LWE (Regev) public-key encryption engine. It is the transmit-side counterpart of the decrypt block.
- Accepts one plaintext symbol plus a BIG_N-bit random subset mask.
- Reads the BIG_N public-key rows one per cycle from an external key RAM and sums the selected rows mod CIPHERTEXT_MODULUS.
- Adds the scaled message to element 0 and presents the (DIMENSION+1)-element ciphertext on a valid/ready output.

Parameters:
PLAINTEXT_MODULUS, 64, plaintext modulus t
PLAINTEXT_WIDTH, 6, log2(t)
DIMENSION, 1, LWE dimension; ciphertext has DIMENSION+1 elements
CIPHERTEXT_MODULUS, 1024, ciphertext modulus q; must equal 2**CIPHERTEXT_WIDTH
CIPHERTEXT_WIDTH, 10, log2(q)
BIG_N, 30, number of public-key rows (samples)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  plaintext and mask valid
in_ready  out  1  engine idle, can accept
plaintext  in  PLAINTEXT_WIDTH  message m
rand_bits  in  BIG_N  subset mask; bit i selects row i
pk_rd_en  out  1  key RAM read strobe
pk_addr  out  $clog2(BIG_N)  key RAM row address
pk_row  in  CIPHERTEXT_WIDTH x [DIMENSION:0]  row data, valid 1 cycle after pk_rd_en
out_valid  out  1  ciphertext valid
out_ready  in  1  downstream accepts
cipher_text  out  CIPHERTEXT_WIDTH x [DIMENSION:0]  ciphertext vector

Behaviour:
- Reset (async assert, sync deassert upstream):
  - state=IDLE, out_valid=0, pk_rd_en=0, pk_addr=0, all cipher_text elements=0.
  - in_ready=1 once rst is low.
- in_ready = (state==IDLE). It is a registered-state decode, with no combinational path from in_valid.
- States:
  - IDLE: on in_valid&&in_ready (cycle T), latch rand_bits. Set acc[0]=plaintext*DELTA mod q, where DELTA=q/t (a left shift by CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH). Set acc[1..DIMENSION]=0, row counter=0, go to FETCH.
  - FETCH: during cycles T+1..T+BIG_N, pk_rd_en=1 and pk_addr=counter (0..BIG_N-1); counter increments each cycle. After addr BIG_N-1, go to DRAIN.
  - Accumulate path: a delayed copy of {rd_en, mask bit} qualifies pk_row on the following cycle. If the qualified mask bit=1, then acc[j] += pk_row[j] mod q for all j; otherwise acc is unchanged. The last accumulate occurs at cycle T+BIG_N+1.
  - DRAIN: one cycle covering the final accumulate. Then out_valid=1 and cipher_text=acc, registered, visible at cycle T+BIG_N+2. Go to DONE.
  - DONE: hold out_valid and cipher_text stable until out_ready. On handshake: out_valid=0, go to IDLE. in_ready=1 in the next cycle.
- Latency: accept -> out_valid is BIG_N+2 cycles (32 at defaults). Throughput is one ciphertext per BIG_N+3 cycles minimum.
- Arithmetic:
  - All sums are unsigned CIPHERTEXT_WIDTH-bit and wrap naturally (q is a power of 2).
  - pk_row elements are treated as residues in [0,q-1].
  - No intermediate width beyond CIPHERTEXT_WIDTH+1 is needed.
- Boundary conditions:
  - rand_bits=0: the ciphertext is just (m*DELTA, 0, ..., 0).
  - in_valid while not IDLE: ignored; plaintext and rand_bits are not re-sampled.
  - out_ready held high: DONE lasts exactly 1 cycle.
  - Reset mid-operation: immediate return to IDLE with the reset values above; the partial accumulation is discarded and there are no further RAM reads.
  - pk_addr is held at the last value outside FETCH. pk_rd_en=0 outside FETCH.

Decomposition:
- Package encrypt_pkg holds:
  - state enum {IDLE, FETCH, DRAIN, DONE};
  - DELTA_SHIFT = CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH;
  - ADDR_WIDTH = $clog2(BIG_N);
  - a ct_vec_t typedef for the [DIMENSION:0] CIPHERTEXT_WIDTH-bit vector.
- One sub-module, encrypt_accum: a DIMENSION+1 lane modular accumulator with load (init value), conditional add-enable, and clear.
- The FSM, counter and RAM interface stay in encrypt.

Test Plan:
- plaintext=5, rand_bits=0, any key -> out_valid at T+32, cipher_text={80,0}; pk_rd_en high exactly 30 cycles, addrs 0..29.
- Key row i = {i, 2i}, rand_bits=all ones, plaintext=5 -> cipher_text[0]=(435+80)=515, cipher_text[1]=870.
- Wrap: all rows={1023,1023}, rand_bits=0b111 (rows 0-2), plaintext=0 -> cipher_text={1021,1021}.
- Backpressure: out_ready low for 5 cycles after out_valid -> cipher_text stable, out_valid held, in_ready=0. Raise out_ready -> out_valid drops next cycle, in_ready=1 next cycle.
- Assert rst at T+10 (mid-FETCH) -> same cycle: pk_rd_en=0, out_valid=0, cipher_text={0,0}. After release, a new encryption of plaintext=1 with rand_bits=0 gives {16,0}, unaffected by the aborted run.
- in_valid held high with changing plaintext throughout an encryption -> only the value at cycle T is used. The next accept occurs only after the out handshake plus 1 cycle.
